// File: rtl/amp_limit_irq_pkg.sv
// Shared amplifier-monitor constants: over-current FSM encodings, status bit
// positions and the I2C sensor addresses used by amp_ctrl.
package amp_pkg;

  typedef enum logic [1:0] {
    OC_NORMAL  = 2'd0,
    OC_PENDING = 2'd1,
    OC_LIMIT   = 2'd2,
    OC_RELEASE = 2'd3
  } oc_state_t;

  localparam int ST_LIMIT = 0;
  localparam int ST_SERR  = 1;
  localparam int ST_STALE = 2;
  localparam int ST_UV    = 3;

  // 7-bit I2C addresses of the current/voltage monitor and the regulator
  localparam logic [6:0] PAC1710_ADDR  = 7'h18;
  localparam logic [6:0] ISL95811_ADDR = 7'h28;

endpackage

// File: rtl/amp_limit_irq_if.sv
// Sample/strobe inputs from amp_ctrl, host config and interrupt outputs.
// slave = monitor block, master = the side driving samples and config.
interface amp_limit_irq_if;
  logic [7:0] v;
  logic [7:0] i;
  logic       v_update;
  logic       i_update;
  logic       vi_err;
  logic       r_err;
  logic [7:0] i_limit;
  logic [7:0] i_release;
  logic [3:0] irq_en;
  logic [3:0] irq_ack;
  logic       peak_clr;
  logic       irq;
  logic [3:0] irq_status;
  logic       limit_active;
  logic [7:0] i_peak;

  modport slave (
    input  v, i, v_update, i_update, vi_err, r_err,
    input  i_limit, i_release, irq_en, irq_ack, peak_clr,
    output irq, irq_status, limit_active, i_peak
  );

  modport master (
    output v, i, v_update, i_update, vi_err, r_err,
    output i_limit, i_release, irq_en, irq_ack, peak_clr,
    input  irq, irq_status, limit_active, i_peak
  );
endinterface

// File: rtl/amp_limit_irq_debounce.sv
// Over-current debounce FSM with hysteresis: TRIP_CNT samples above limit to
// enter, CLR_CNT samples below release to leave. enter_pulse_o marks the entry edge.
module amp_debounce
  import amp_pkg::*;
#(
  parameter int TRIP_CNT = 3,
  parameter int CLR_CNT  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  input  logic above_i,
  input  logic below_i,
  output logic active_o,
  output logic enter_pulse_o
);

  localparam logic [3:0] TRIP_C = 4'(TRIP_CNT);
  localparam logic [3:0] CLR_C  = 4'(CLR_CNT);

  oc_state_t  state_q;
  logic [3:0] cnt_q;
  logic       active_q;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  // Combinational so the sticky status bit lands on the same edge as LIMIT.
  assign enter_pulse_o = strobe_i && above_i &&
                         (((state_q == OC_NORMAL)  && (TRIP_C == 4'd1)) ||
                          ((state_q == OC_PENDING) && (cnt_inc == TRIP_C)));
  assign active_o = active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OC_NORMAL;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
    end else if (strobe_i) begin
      case (state_q)
        OC_NORMAL: if (above_i) begin
          if (TRIP_C == 4'd1) begin
            state_q  <= OC_LIMIT;
            cnt_q    <= 4'd0;
            active_q <= 1'b1;
          end else begin
            state_q <= OC_PENDING;
            cnt_q   <= 4'd1;
          end
        end
        OC_PENDING: if (above_i) begin
          if (cnt_inc == TRIP_C) begin
            state_q  <= OC_LIMIT;
            cnt_q    <= 4'd0;
            active_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end else begin
          state_q <= OC_NORMAL;
          cnt_q   <= 4'd0;
        end
        OC_LIMIT: if (below_i) begin
          if (CLR_C == 4'd1) begin
            state_q  <= OC_NORMAL;
            cnt_q    <= 4'd0;
            active_q <= 1'b0;
          end else begin
            state_q <= OC_RELEASE;
            cnt_q   <= 4'd1;
          end
        end
        OC_RELEASE: if (below_i) begin
          if (cnt_inc == CLR_C) begin
            state_q  <= OC_NORMAL;
            cnt_q    <= 4'd0;
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end else begin
          state_q <= OC_LIMIT;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q  <= OC_NORMAL;
          cnt_q    <= 4'd0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/amp_limit_irq.sv
// Amplifier current/voltage monitor: debounced over-current, sensor error, stale
// watchdog, peak tracker and sticky irq status. Optional under-voltage: AMP_LIMIT_UV_EN.
module amp_limit_irq
  import amp_pkg::*;
#(
  parameter int          SYS_FREQ  = 25_000_000,
  parameter int          TRIP_CNT  = 3,
  parameter int          CLR_CNT   = 3,
  parameter int unsigned STALE_CYC = SYS_FREQ / 10,
  parameter logic [7:0]  V_MIN     = 8'd40
) (
  input logic            clk,
  input logic            rst_n,
  amp_limit_irq_if.slave bus
);

  localparam logic [31:0] STALE_LIM = 32'(STALE_CYC);

  logic [31:0] stale_q, stale_d;
  logic [7:0]  peak_q, peak_d;
  logic [3:0]  status_q, status_d, set_vec;
  logic        irq_q;
  logic        stale_hit, uv_set, enter_pulse, active;

  // Missing data during a sensor error must not advance the debounce.
  amp_debounce #(.TRIP_CNT(TRIP_CNT), .CLR_CNT(CLR_CNT)) u_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .strobe_i      (bus.i_update && !bus.vi_err && !bus.r_err),
    .above_i       (bus.i > bus.i_limit),
    .below_i       (bus.i < bus.i_release),
    .active_o      (active),
    .enter_pulse_o (enter_pulse)
  );

`ifdef AMP_LIMIT_UV_EN
  assign uv_set = bus.v_update && (bus.v < V_MIN);
`else
  logic unused_uv;
  assign unused_uv = ^{bus.v, bus.v_update, V_MIN};
  assign uv_set    = 1'b0;
`endif

  assign stale_hit = !bus.i_update && (stale_q == STALE_LIM - 32'd1);

  always_comb begin
    stale_d = stale_q;
    if (bus.i_update) stale_d = 32'd0;
    else if (stale_q != STALE_LIM) stale_d = stale_q + 32'd1;

    peak_d = peak_q;
    if (bus.peak_clr) peak_d = 8'd0;
    if (bus.i_update && (bus.peak_clr || (bus.i > peak_q))) peak_d = bus.i;

    set_vec           = 4'd0;
    set_vec[ST_LIMIT] = enter_pulse;
    set_vec[ST_SERR]  = bus.vi_err || bus.r_err;
    set_vec[ST_STALE] = stale_hit;
    set_vec[ST_UV]    = uv_set;
    status_d = (status_q & ~bus.irq_ack) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_q  <= 32'd0;
      peak_q   <= 8'd0;
      status_q <= 4'd0;
      irq_q    <= 1'b0;
    end else begin
      stale_q  <= stale_d;
      peak_q   <= peak_d;
      status_q <= status_d;
      irq_q    <= |(status_q & bus.irq_en);
    end
  end

  assign bus.irq          = irq_q;
  assign bus.irq_status   = status_q;
  assign bus.limit_active = active;
  assign bus.i_peak       = peak_q;

endmodule

// File: tb/tb_amp_limit_irq.sv
// Directed bench for amp_limit_irq: per-cycle vector table plus hand sequences
// for async reset, irq_en masking, stale watchdog and under-voltage.
module tb_amp_limit_irq;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  amp_limit_irq_if bus ();

  amp_limit_irq #(
    .TRIP_CNT  (3),
    .CLR_CNT   (3),
    .STALE_CYC (1000),
    .V_MIN     (8'd40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iu;
    logic [7:0] i;
    logic [3:0] ack;
    logic       verr;
    logic       rerr;
    logic       pclr;
    logic       exp_la;
    logic [3:0] exp_st;
    logic       exp_irq;
    logic [7:0] exp_pk;
  } vec_t;

  vec_t vt[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    bus.v_update = 1'b0;
    bus.i_update = 1'b0;
    bus.vi_err   = 1'b0;
    bus.r_err    = 1'b0;
    bus.irq_ack  = 4'd0;
    bus.peak_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic sample(input logic [7:0] val);
    bus.i        = val;
    bus.i_update = 1'b1;
    cyc();
  endtask

  function automatic vec_t mk(input logic iu, input logic [7:0] i, input logic [3:0] ack,
                              input logic verr, input logic rerr, input logic pclr,
                              input logic la, input logic [3:0] st, input logic irq,
                              input logic [7:0] pk);
    vec_t r;
    r.iu = iu; r.i = i; r.ack = ack; r.verr = verr; r.rerr = rerr; r.pclr = pclr;
    r.exp_la = la; r.exp_st = st; r.exp_irq = irq; r.exp_pk = pk;
    return r;
  endfunction

  initial begin
    logic ok;
    pass_cnt  = 0;
    total_cnt = 0;
    bus.v         = 8'd100;
    bus.i         = 8'd0;
    bus.i_limit   = 8'd200;
    bus.i_release = 8'd180;
    bus.irq_en    = 4'hF;

    //           iu  i     ack   ve rr pc  la st   irq pk
    vt[0]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[1]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[2]  = mk(1, 150, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[3]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[4]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[5]  = mk(0, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[6]  = mk(1, 200, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[7]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[8]  = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[9]  = mk(1, 201, 4'h0, 0, 0, 0,  1, 4'h1, 0, 201);
    vt[10] = mk(0, 201, 4'h0, 0, 0, 0,  1, 4'h1, 1, 201);
    vt[11] = mk(1, 170, 4'h0, 0, 0, 0,  1, 4'h1, 1, 201);
    vt[12] = mk(1, 170, 4'h1, 0, 0, 0,  1, 4'h0, 1, 201);
    vt[13] = mk(1, 185, 4'h0, 0, 0, 0,  1, 4'h0, 0, 201);
    vt[14] = mk(1, 180, 4'h0, 0, 0, 0,  1, 4'h0, 0, 201);
    vt[15] = mk(1, 170, 4'h0, 0, 0, 0,  1, 4'h0, 0, 201);
    vt[16] = mk(1, 170, 4'h0, 0, 0, 0,  1, 4'h0, 0, 201);
    vt[17] = mk(1, 170, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[18] = mk(1, 201, 4'h0, 1, 0, 0,  0, 4'h2, 0, 201);
    vt[19] = mk(1, 201, 4'h0, 0, 0, 0,  0, 4'h2, 1, 201);
    vt[20] = mk(0, 201, 4'h2, 1, 0, 0,  0, 4'h2, 1, 201);
    vt[21] = mk(0, 201, 4'h2, 0, 0, 0,  0, 4'h0, 1, 201);
    vt[22] = mk(0, 201, 4'h0, 0, 0, 0,  0, 4'h0, 0, 201);
    vt[23] = mk(0, 201, 4'h0, 0, 0, 1,  0, 4'h0, 0, 0);
    vt[24] = mk(1, 10,  4'h0, 0, 0, 0,  0, 4'h0, 0, 10);
    vt[25] = mk(1, 90,  4'h0, 0, 0, 0,  0, 4'h0, 0, 90);
    vt[26] = mk(1, 40,  4'h0, 0, 0, 0,  0, 4'h0, 0, 90);
    vt[27] = mk(1, 30,  4'h0, 0, 0, 1,  0, 4'h0, 0, 30);
    vt[28] = mk(1, 20,  4'h0, 0, 0, 0,  0, 4'h0, 0, 30);
    vt[29] = mk(0, 20,  4'h0, 0, 1, 0,  0, 4'h2, 0, 30);
    vt[30] = mk(0, 20,  4'h2, 0, 0, 0,  0, 4'h0, 1, 30);
    vt[31] = mk(0, 20,  4'h0, 0, 0, 0,  0, 4'h0, 0, 30);

    do_reset();
    chk("reset_limit_active", {31'd0, bus.limit_active}, 32'd0);
    chk("reset_status", {28'd0, bus.irq_status}, 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    chk("reset_peak", {24'd0, bus.i_peak}, 32'd0);

    for (int n = 0; n < 32; n++) begin
      bus.i        = vt[n].i;
      bus.i_update = vt[n].iu;
      bus.irq_ack  = vt[n].ack;
      bus.vi_err   = vt[n].verr;
      bus.r_err    = vt[n].rerr;
      bus.peak_clr = vt[n].pclr;
      cyc();
      chk($sformatf("vec%0d_limit_active", n), {31'd0, bus.limit_active}, {31'd0, vt[n].exp_la});
      chk($sformatf("vec%0d_status", n), {28'd0, bus.irq_status}, {28'd0, vt[n].exp_st});
      chk($sformatf("vec%0d_irq", n), {31'd0, bus.irq}, {31'd0, vt[n].exp_irq});
      chk($sformatf("vec%0d_peak", n), {24'd0, bus.i_peak}, {24'd0, vt[n].exp_pk});
    end

    // Async reset in the middle of PENDING, with irq already high
    do_reset();
    bus.vi_err = 1'b1;
    cyc();
    sample(8'd201);
    sample(8'd201);
    chk("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'd0, bus.irq}, 32'd0);
    chk("async_rst_status", {28'd0, bus.irq_status}, 32'd0);
    chk("async_rst_peak", {24'd0, bus.i_peak}, 32'd0);
    chk("async_rst_limit", {31'd0, bus.limit_active}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample(8'd201);
    sample(8'd201);
    chk("post_rst_no_trip", {31'd0, bus.limit_active}, 32'd0);
    sample(8'd201);
    chk("post_rst_trip", {31'd0, bus.limit_active}, 32'd1);
    chk("post_rst_status", {28'd0, bus.irq_status}, 32'h1);

    // irq_en masking: irq follows a cycle later, status untouched
    cyc();
    chk("en_irq_high", {31'd0, bus.irq}, 32'd1);
    bus.irq_en = 4'h0;
    cyc();
    chk("en_clr_irq", {31'd0, bus.irq}, 32'd0);
    chk("en_clr_status_kept", {28'd0, bus.irq_status}, 32'h1);
    bus.irq_en = 4'hF;
    cyc();
    chk("en_set_irq", {31'd0, bus.irq}, 32'd1);

    // Stale watchdog
    do_reset();
    repeat (999) @(posedge clk);
    #1;
    chk("stale_before", {31'd0, bus.irq_status[2]}, 32'd0);
    @(posedge clk);
    #1;
    chk("stale_set", {31'd0, bus.irq_status[2]}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("stale_sticky", {31'd0, bus.irq_status[2]}, 32'd1);
    sample(8'd0);
    chk("stale_after_update", {31'd0, bus.irq_status[2]}, 32'd1);
    bus.irq_ack = 4'b0100;
    cyc();
    chk("stale_ack", {31'd0, bus.irq_status[2]}, 32'd0);
    ok = 1'b1;
    repeat (998) begin
      @(posedge clk);
      #1;
      if (bus.irq_status[2]) ok = 1'b0;
    end
    chk("stale_quiet_after_ack", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    chk("stale_reset_again", {31'd0, bus.irq_status[2]}, 32'd1);

    // Under-voltage
    do_reset();
`ifdef AMP_LIMIT_UV_EN
    bus.v = 8'd39; bus.v_update = 1'b1;
    cyc();
    chk("uv_39_sets", {31'd0, bus.irq_status[3]}, 32'd1);
    bus.irq_ack = 4'b1000;
    cyc();
    chk("uv_ack", {31'd0, bus.irq_status[3]}, 32'd0);
    bus.v = 8'd40; bus.v_update = 1'b1;
    cyc();
    chk("uv_40_no_set", {31'd0, bus.irq_status[3]}, 32'd0);
`else
    bus.v = 8'd0; bus.v_update = 1'b1;
    cyc();
    chk("uv_disabled", {31'd0, bus.irq_status[3]}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
